// File: rtl/prog_loader.sv
// Program-memory loader: assembles a byte stream into 16-bit words and serves core fetches.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing checksum byte and the sticky load_err flag.
module prog_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0018
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_rom,
    output logic [15:0] q_rom,
    input  logic        load_start,
    input  logic [15:0] load_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        core_run,
    output logic        load_done,
    output logic        load_err
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HI, LO, CHK, DONE} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, HI, LO, DONE} state_t;
    assign load_err = 1'b0;
`endif

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [7:0]  hi_byte;
    logic [15:0] mem [DEPTH];

    logic take;
    logic last_word;
    logic idx_in_range;
    logic rd_in_range;

    assign take         = in_valid && in_ready;
    assign last_word    = (idx == cnt - 16'd1);
    // Upper address bits must be zero; no wrap-around into the array.
    assign idx_in_range = ((idx >> ADDR_W) == 16'd0);
    assign rd_in_range  = ((address_rom >> ADDR_W) == 16'd0);

    // Data path: pending high byte and memory, deliberately not reset.
    always_ff @(posedge clock) begin
        if (state == HI && take) begin
            hi_byte <= in_data;
        end
        if (!reset && state == LO && take && idx_in_range) begin
            mem[idx[ADDR_W-1:0]] <= {hi_byte, in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            core_run  <= 1'b0;
            load_done <= 1'b0;
            cnt       <= 16'd0;
            idx       <= 16'd0;
            q_rom     <= NOP_WORD;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
            load_err  <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            // Read sees the pre-edge contents, so a same-edge write returns old data.
            q_rom <= (core_run && rd_in_range) ? mem[address_rom[ADDR_W-1:0]] : NOP_WORD;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        cnt      <= load_count;
                        idx      <= 16'd0;
                        core_run <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                        if (load_count == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= CHK;
                            in_ready <= 1'b1;
`else
                            state    <= DONE;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state    <= HI;
                            in_ready <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (take) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum + in_data;
`endif
                        state <= LO;
                    end
                end
                LO: begin
                    if (take) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum + in_data;
`endif
                        idx <= idx + 16'd1;
                        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= CHK;
`else
                            state    <= DONE;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state <= HI;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        if (in_data != csum) begin
                            load_err <= 1'b1;
                        end
                        state    <= DONE;
                        in_ready <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    load_done <= 1'b1;
                    core_run  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (ADDR_W=8 and ADDR_W=2) share one stimulus stream
// and are checked against a word-level model of the loaded program.
module tb_prog_loader;

    localparam logic [15:0] NOP = 16'h0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_rom;
    logic        load_start;
    logic [15:0] load_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [15:0] q_a, q_b;
    logic        rdy_a, rdy_b, run_a, run_b, done_a, done_b, err_a, err_b;

    prog_loader #(.ADDR_W(8), .NOP_WORD(16'h0018)) dut_a (
        .clock(clk), .reset(reset), .address_rom(address_rom), .q_rom(q_a),
        .load_start(load_start), .load_count(load_count), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_a), .core_run(run_a), .load_done(done_a),
        .load_err(err_a)
    );

    prog_loader #(.ADDR_W(2), .NOP_WORD(16'h0018)) dut_b (
        .clock(clk), .reset(reset), .address_rom(address_rom), .q_rom(q_b),
        .load_start(load_start), .load_count(load_count), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_b), .core_run(run_b), .load_done(done_b),
        .load_err(err_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int snap_a = 0;
    int snap_b = 0;
    bit tog = 1'b0;

    logic [15:0] mem_a [256];
    bit          wr_a  [256];
    logic [15:0] mem_b [4];
    bit          wr_b  [4];
    bit          m_run = 1'b0;
    bit          m_err = 1'b0;
    logic [7:0]  data [$];

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_run_a"},  32'(run_a),  32'(m_run));
        chk({tag, "_run_b"},  32'(run_b),  32'(m_run));
        chk({tag, "_rdy_a"},  32'(rdy_a),  32'd0);
        chk({tag, "_rdy_b"},  32'(rdy_b),  32'd0);
        chk({tag, "_err_a"},  32'(err_a),  32'(m_err));
        chk({tag, "_err_b"},  32'(err_b),  32'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; load_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_run = 1'b0; m_err = 1'b0;
        chk_idle("reset");
        chk("reset_done_a", 32'(done_a), 32'd0);
        chk("reset_q_a", 32'(q_a), 32'(NOP));
        chk("reset_q_b", 32'(q_b), 32'(NOP));
    endtask

    task automatic start(input logic [15:0] n);
        @(negedge clk);
        snap_a = done_cnt_a; snap_b = done_cnt_b;
        load_start = 1'b1; load_count = n; in_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0; load_count = 16'($urandom);
    endtask

    // mode 0: always valid, 1: valid toggles every cycle, 2: random gaps
    task automatic send_byte(input logic [7:0] b, input int mode);
        bit   acc = 1'b0;
        int   tries = 0;
        bit   v;
        logic r;
        while (!acc && tries < 200) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       begin tog = ~tog; v = tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            in_data  = v ? b : 8'($urandom);
            r = rdy_a;
            @(posedge clk);
            if (v && r === 1'b1) acc = 1'b1;
            tries++;
        end
        chk("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic finish(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk({tag, "_done_pulses_a"}, 32'(done_cnt_a - snap_a), 32'd1);
        chk({tag, "_done_pulses_b"}, 32'(done_cnt_b - snap_b), 32'd1);
        chk_idle(tag);
    endtask

    task automatic put_word(input int i, input logic [15:0] w);
        if (i < 256) begin mem_a[i] = w; wr_a[i] = 1'b1; end
        if (i < 4)   begin mem_b[i] = w; wr_b[i] = 1'b1; end
    endtask

    // Session of n words taken from data[0 .. 2n-1]; bad_chk sends 00 as checksum.
    task automatic load(input int n, input int mode, input bit bad_chk);
        logic [7:0] sum = 8'd0;
        logic [7:0] cb;
        start(16'(n));
        for (int i = 0; i < 2 * n; i++) begin
            send_byte(data[i], mode);
            sum = sum + data[i];
        end
        cb = bad_chk ? 8'h00 : sum;
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(cb, mode);
        if (cb != sum) m_err = 1'b1;
`endif
        for (int i = 0; i < n; i++) put_word(i, {data[2 * i], data[2 * i + 1]});
        m_run = 1'b1;
        finish("load");
    endtask

    task automatic rd(input logic [15:0] addr);
        @(negedge clk);
        address_rom = addr;
        @(negedge clk);
        if (!m_run || addr >= 16'd256) chk("rd_a", 32'(q_a), 32'(NOP));
        else if (wr_a[addr[7:0]])      chk("rd_a", 32'(q_a), 32'(mem_a[addr[7:0]]));
        if (!m_run || addr >= 16'd4)   chk("rd_b", 32'(q_b), 32'(NOP));
        else if (wr_b[addr[1:0]])      chk("rd_b", 32'(q_b), 32'(mem_b[addr[1:0]]));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) wr_a[i] = 1'b0;
        for (int i = 0; i < 4; i++)   wr_b[i] = 1'b0;
        reset = 1'b1; address_rom = 16'd0; load_start = 1'b0; load_count = 16'd0;
        in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("por");
        rd(16'd0);

        // Basic two-word program
        data = '{8'h12, 8'h34, 8'h56, 8'h78};
        load(2, 0, 1'b0);
        rd(16'd0);
        rd(16'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        load(2, 0, 1'b1);
        chk("bad_chk_err_a", 32'(err_a), 32'd1);
        rd(16'd0);
`endif
        do_reset();
        rd(16'd0);

        // Same program with in_valid toggling each cycle
        load(2, 1, 1'b0);
        rd(16'd0);
        rd(16'd1);

        // load_start while waiting for the low byte must be ignored
        start(16'd1);
        send_byte(8'h5A, 0);
        @(negedge clk);
        in_valid = 1'b0; load_start = 1'b1; load_count = 16'd7;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'hC3, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h5A + 8'hC3, 0);
`endif
        put_word(0, 16'h5AC3);
        m_run = 1'b1;
        finish("ls_ignored");
        rd(16'd0);
        rd(16'd1);

        // Zero-length session
        start(16'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        m_run = 1'b1;
        finish("zero_len");
        rd(16'd0);

        // Reset in the middle of a session, then a fresh one-word load
        start(16'd2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        put_word(0, 16'h1122);
        do_reset();
        data = '{8'hAB, 8'hCD};
        load(1, 0, 1'b0);
        rd(16'd0);
        rd(16'd1);

        // Five words: the ADDR_W=2 instance keeps four and discards the fifth
        data.delete();
        repeat (10) data.push_back(8'($urandom));
        load(5, 2, 1'b0);
        for (int i = 0; i < 5; i++) rd(16'(i));
        rd(16'h0100);
        rd(16'hFFFF);

        // Randomized sessions
        repeat (4) begin
            n = $urandom_range(1, 6);
            data.delete();
            repeat (2 * n) data.push_back(8'($urandom));
            load(n, $urandom_range(0, 2), 1'b0);
            for (int i = 0; i <= n; i++) rd(16'(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width; depth = 2**ADDR_W 16-bit words.
REQ-002 Parameter NOP_WORD, default 16'h0018, word returned for out-of-range or unloaded-run reads.
REQ-003 clock  input  1  single clock; all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address_rom  input  16  word address driven by the core's fetch stage.
REQ-006 q_rom  output  16  instruction word returned to the core.
REQ-007 load_start  input  1  one-cycle pulse that begins a load session.
REQ-008 load_count  input  16  number of words in the session, sampled on load_start.
REQ-009 in_valid  input  1  byte-stream valid.
REQ-010 in_data  input  8  byte-stream data.
REQ-011 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high on a clock edge.
REQ-012 core_run  output  1  high when memory holds a complete program and the core may fetch.
REQ-013 load_done  output  1  one-cycle pulse at session end.
REQ-014 load_err  output  1  sticky checksum error flag (CHECKSUM_EN only; tied 0 otherwise).

Function
REQ-015 State machine states: IDLE, HI, LO, CHK, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=0; on load_start, latch load_count, clear word index and checksum, clear core_run; go to HI, or to DONE (CHK with CHECKSUM_EN) if load_count=0.
REQ-017 HI: in_ready=1; an accepted byte becomes bits [15:8] of the pending word; go to LO.
REQ-018 LO: in_ready=1; an accepted byte forms bits [7:0]; write {hi,lo} at the word index in the same edge; increment the index; go to HI, or to DONE/CHK after the last word.
REQ-019 Words whose index is >= depth are accepted and discarded; no address wrap-around.
REQ-020 CHK: in_ready=1; accept one checksum byte; set load_err if it differs from the 8-bit modulo sum of all data bytes; go to DONE.
REQ-021 DONE: pulse load_done for one cycle, set core_run=1, go to IDLE.
REQ-022 load_start during HI, LO or CHK is ignored.
REQ-023 q_rom is registered, one-cycle latency: the value at edge N reflects address_rom sampled at edge N.
REQ-024 q_rom = NOP_WORD when address_rom >= depth or core_run=0.
REQ-025 A read of the address written on the same edge returns the old contents (read-before-write).
REQ-026 An in_valid without in_ready causes no transfer and no state change; the byte stays pending.

Reset
REQ-027 Reset, applied at any cycle including mid-session, forces state IDLE, in_ready=0, core_run=0, load_done=0, load_err=0, q_rom=NOP_WORD, word index=0, checksum=0.
REQ-028 Memory contents are not cleared by reset; a new session is required before core_run rises again.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN defined: CHK state, checksum accumulator and load_err are implemented as in REQ-020.
REQ-030 Macro not defined: CHK state is absent, the last LO byte transitions directly to DONE, and load_err is constant 0.

Verification
REQ-031 Reset, then address_rom=0 -> q_rom=16'h0018 one cycle later, core_run=0, in_ready=0.
REQ-032 load_count=2, bytes 12 34 56 78 (plus checksum 14 with macro) -> load_done pulse, core_run=1, address 0 -> 16'h1234, address 1 -> 16'h5678, load_err=0.
REQ-033 Same load with the checksum byte 00 and macro defined -> core_run=1, load_err=1.
REQ-034 in_valid toggled 1/0 every cycle during the load -> identical memory contents to REQ-032; no dropped or duplicated bytes.
REQ-035 Reset asserted after 3 bytes, then a new load_count=1 session with bytes AB CD -> address 0 = 16'hABCD, core_run=1.
REQ-036 ADDR_W=2, load_count=5 -> words 0-3 stored, 5th word accepted and discarded, address 4 -> 16'h0018, load_done pulses once.
